// File: rtl/stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// stopwatch_display_scan: 8-digit multiplexed 7-segment scanner, HH.MM.SS.CC
// Revision: 1.0
// ============================================================================
module stopwatch_display_scan #(
   parameter int SCAN_DIV     = 125,
   parameter int BLINK_FRAMES = 31
) (
   input  logic       clk_scan,
   input  logic       rst_n,
   input  logic [7:0] centisec,
   input  logic [7:0] sec,
   input  logic [7:0] min,
   input  logic [7:0] hour,
   input  logic       blink_en,
   output logic [7:0] seg,
   output logic [7:0] an,
   output logic       frame_done
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = $clog2(BLINK_FRAMES + 1);

   logic [PW-1:0] r_presc;
   logic [2:0]    r_idx;
   logic          r_active;
   logic [7:0]    r_sh_cs, r_sh_sec, r_sh_min, r_sh_hour;
   logic [BW-1:0] r_blink_cnt;
   logic          r_phase;

   logic       w_tick, w_wrap, w_dp, w_blank;
   logic [7:0] w_field;
   logic [6:0] w_sat;
   logic [3:0] w_digit;
   logic [6:0] w_glyph;

   assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
   assign w_wrap = w_tick && (r_idx == 3'd7);

   always_comb begin
      w_field = r_sh_cs;
      case (r_idx[2:1])
         2'd0: w_field = r_sh_cs;
         2'd1: w_field = r_sh_sec;
         2'd2: w_field = r_sh_min;
         2'd3: w_field = r_sh_hour;
         default: w_field = r_sh_cs;
      endcase
   end

   assign w_sat   = (w_field > 8'd99) ? 7'd99 : w_field[6:0];
   assign w_digit = r_idx[0] ? 4'(w_sat / 7'd10) : 4'(w_sat % 7'd10);
   assign w_dp    = (r_idx == 3'd2) || (r_idx == 3'd4) || (r_idx == 3'd6);
   // Hour/minute slots go dark but keep their time slot so the scan rate is unchanged
   assign w_blank = blink_en && r_phase && r_idx[2];

   always_comb begin
      w_glyph = 7'h00;
      case (w_digit)
         4'd0: w_glyph = 7'h3F;
         4'd1: w_glyph = 7'h06;
         4'd2: w_glyph = 7'h5B;
         4'd3: w_glyph = 7'h4F;
         4'd4: w_glyph = 7'h66;
         4'd5: w_glyph = 7'h6D;
         4'd6: w_glyph = 7'h7D;
         4'd7: w_glyph = 7'h07;
         4'd8: w_glyph = 7'h7F;
         4'd9: w_glyph = 7'h6F;
         default: w_glyph = 7'h00;
      endcase
   end

   always_ff @(posedge clk_scan or negedge rst_n) begin
      if (!rst_n) begin
         r_presc     <= '0;
         r_idx       <= 3'd7;
         r_active    <= 1'b0;
         r_sh_cs     <= 8'h00;
         r_sh_sec    <= 8'h00;
         r_sh_min    <= 8'h00;
         r_sh_hour   <= 8'h00;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         frame_done  <= 1'b0;
         seg         <= 8'h00;
         an          <= 8'h00;
      end else begin
         r_presc    <= w_tick ? '0 : r_presc + PW'(1);
         frame_done <= w_wrap;
         if (w_tick) begin
            r_idx    <= r_idx + 3'd1;
            r_active <= 1'b1;
         end
         if (w_wrap) begin
            r_sh_cs   <= centisec;
            r_sh_sec  <= sec;
            r_sh_min  <= min;
            r_sh_hour <= hour;
            if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
               r_blink_cnt <= '0;
               r_phase     <= ~r_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + BW'(1);
            end
         end
         // Output stage presents the slot selected during the previous cycle
         if (!r_active || w_blank) begin
            an  <= 8'h00;
            seg <= 8'h00;
         end else begin
            an  <= 8'd1 << r_idx;
            seg <= {w_dp, w_glyph};
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_scan.sv
`default_nettype none
// Testbench for stopwatch_display_scan: frame-level reference model plus vector table.
module tb_stopwatch_display_scan;
   localparam int D  = 2;
   localparam int BF = 1;

   logic       clk_scan = 1'b0;
   logic       rst_n    = 1'b0;
   logic [7:0] centisec = 8'd78, sec = 8'd56, min = 8'd34, hour = 8'd12;
   logic       blink_en = 1'b0;
   logic [7:0] seg, an;
   logic       frame_done;

   int compared   = 0;
   int mismatched = 0;

   stopwatch_display_scan #(.SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
      .clk_scan(clk_scan), .rst_n(rst_n), .centisec(centisec), .sec(sec),
      .min(min), .hour(hour), .blink_en(blink_en), .seg(seg), .an(an),
      .frame_done(frame_done)
   );

   always #5 clk_scan = ~clk_scan;

   // ---------------- reference model ----------------
   // Everything is derived from the number of clock edges since reset release.
   int         n = 0;
   int         snap[4] = '{0, 0, 0, 0};   // cs, sec, min, hour
   logic [7:0] exp_an = 8'h00, exp_seg = 8'h00;
   logic       exp_fd = 1'b0;
   logic [7:0] glyph_tab[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

   function automatic logic [7:0] model_seg(int slot, int f0, int f1, int f2, int f3);
      int v, d;
      int fl[4];
      fl = '{f0, f1, f2, f3};
      v = fl[slot / 2];
      if (v > 99) v = 99;
      d = (slot % 2 == 1) ? v / 10 : v % 10;
      return glyph_tab[d] | ((slot == 2 || slot == 4 || slot == 6) ? 8'h80 : 8'h00);
   endfunction

   always @(posedge clk_scan or negedge rst_n) begin
      int m, t, slot, fr, ph;
      if (!rst_n) begin
         n = 0;
         exp_an = 8'h00; exp_seg = 8'h00; exp_fd = 1'b0;
      end else begin
         m = n;
         n = n + 1;
         if (m >= D) begin
            t    = m / D;
            slot = (t - 1) % 8;
            fr   = (t - 1) / 8;
            ph   = ((fr + 1) / BF) % 2;
            if (blink_en && ph == 1 && slot >= 4) begin
               exp_an = 8'h00; exp_seg = 8'h00;
            end else begin
               exp_an  = 8'h01 << slot;
               exp_seg = model_seg(slot, snap[0], snap[1], snap[2], snap[3]);
            end
         end else begin
            exp_an = 8'h00; exp_seg = 8'h00;
         end
         exp_fd = (n % D == 0) && (((n / D) - 1) % 8 == 0);
         if (exp_fd) snap = '{int'(centisec), int'(sec), int'(min), int'(hour)};
      end
   end

   always @(negedge clk_scan) begin
      compared++;
      if (an !== exp_an || seg !== exp_seg || frame_done !== exp_fd) begin
         mismatched++;
         $display("FAIL model t=%0t: an=%h seg=%h fd=%b, required an=%h seg=%h fd=%b",
                  $time, an, seg, frame_done, exp_an, exp_seg, exp_fd);
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic wait_fd_rise(input string name);
      int k;
      for (k = 0; k < 40 * D && frame_done; k++) @(negedge clk_scan);
      for (k = 0; k < 40 * D && !frame_done; k++) @(negedge clk_scan);
      if (!frame_done) check({name, "_fd_timeout"}, 8'h00, 8'h01);
   endtask

   task automatic wait_an(input string name, input logic [7:0] target);
      int k;
      for (k = 0; k < 40 * D && an !== target; k++) @(negedge clk_scan);
      if (an !== target) check({name, "_an_timeout"}, an, target);
   endtask

   typedef struct {
      logic [7:0]       h, m, s, cs;
      logic [7:0][7:0]  exp;   // indexed by slot
   } vec_t;
   vec_t vecs[4];

   initial begin
      int lit_hi, lit_lo, fds, k;
      vecs[0].h = 8'd12;  vecs[0].m = 8'd34;  vecs[0].s = 8'd56;  vecs[0].cs = 8'd78;
      vecs[0].exp = {8'h06, 8'hDB, 8'h4F, 8'hE6, 8'h6D, 8'hFD, 8'h07, 8'h7F};
      vecs[1].h = 8'd150; vecs[1].m = 8'd0;   vecs[1].s = 8'd59;  vecs[1].cs = 8'd0;
      vecs[1].exp = {8'h6F, 8'hEF, 8'h3F, 8'hBF, 8'h6D, 8'hEF, 8'h3F, 8'h3F};
      vecs[2].h = 8'd99;  vecs[2].m = 8'd59;  vecs[2].s = 8'd0;   vecs[2].cs = 8'd99;
      vecs[2].exp = {8'h6F, 8'hEF, 8'h6D, 8'hEF, 8'h3F, 8'hBF, 8'h6F, 8'h6F};
      vecs[3].h = 8'd255; vecs[3].m = 8'd200; vecs[3].s = 8'd100; vecs[3].cs = 8'd255;
      vecs[3].exp = {8'h6F, 8'hEF, 8'h6F, 8'hEF, 8'h6F, 8'hEF, 8'h6F, 8'h6F};

      repeat (3) @(negedge clk_scan);
      check("reset_an", an, 8'h00);
      check("reset_seg", seg, 8'h00);
      check("reset_fd", {7'd0, frame_done}, 8'h00);
      rst_n = 1'b1;

      // vector table, first row is the frame straight after reset
      for (int i = 0; i < 4; i++) begin
         hour = vecs[i].h; min = vecs[i].m; sec = vecs[i].s; centisec = vecs[i].cs;
         wait_fd_rise("vec");
         for (int s = 0; s < 8; s++) begin
            wait_an("vec", 8'h01 << s);
            check($sformatf("vec%0d_slot%0d", i, s), seg, vecs[i].exp[s]);
         end
      end

      // tear-free snapshot: sec changes while slot 3 is on display
      hour = 8'd12; min = 8'd34; sec = 8'd59; centisec = 8'd78;
      wait_fd_rise("tear");
      wait_an("tear", 8'h08);
      sec = 8'd0;
      check("tear_same_frame", seg, 8'h6D);
      wait_fd_rise("tear2");
      wait_an("tear2", 8'h04);
      check("tear_next_frame", seg, 8'hBF);

      // blink: over two full frames exactly one frame lights slots 4-7
      blink_en = 1'b1;
      wait_fd_rise("blink");
      lit_hi = 0; lit_lo = 0;
      for (k = 0; k < 16 * D; k++) begin
         @(negedge clk_scan);
         if (an[7:4] != 4'h0) lit_hi++;
         if (an[3:0] != 4'h0) lit_lo++;
      end
      check("blink_hi_cycles", 8'(lit_hi), 8'(4 * D));
      check("blink_lo_cycles", 8'(lit_lo), 8'(8 * D));
      blink_en = 1'b0;

      // frame_done rate
      fds = 0;
      for (k = 0; k < 40 * D; k++) begin
         @(negedge clk_scan);
         if (frame_done) fds++;
      end
      check("fd_count", 8'(fds), 8'd5);

      // randomized run against the model
      for (k = 0; k < 3000; k++) begin
         @(negedge clk_scan);
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0: centisec = 8'($urandom_range(0, 120));
               1: sec      = 8'($urandom_range(0, 255));
               2: min      = 8'($urandom_range(0, 110));
               default: hour = 8'($urandom_range(0, 255));
            endcase
         end
         if ($urandom_range(0, 63) == 0) blink_en = ~blink_en;
      end
      blink_en = 1'b0;

      // asynchronous reset between clock edges
      repeat (5) @(negedge clk_scan);
      @(posedge clk_scan);
      #1 rst_n = 1'b0;
      #1;
      check("arst_an", an, 8'h00);
      check("arst_seg", seg, 8'h00);
      check("arst_fd", {7'd0, frame_done}, 8'h00);
      @(negedge clk_scan);
      rst_n = 1'b1;
      for (k = 1; k <= 20; k++) begin
         @(posedge clk_scan);
         #1;
         if (an == 8'h01) break;
      end
      check("arst_first_lit", 8'(k), 8'(D + 1));
      repeat (20 * D) @(negedge clk_scan);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
